// File: rtl/fxp8s_pkg.sv
// Shared FXP8S definitions: operand format, sequencer state encoding and a
// counter-width helper.
package fxp8s_pkg;

  localparam int FXP8S_WIDTH   = 8;
  localparam int FXP8S_LSB_POW = -3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_ROW   = 3'd2,
    ST_COL   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_CAPT  = 3'd5,
    ST_RESP  = 3'd6
  } seq_state_e;

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fxp8s_pe_seq.sv
// Job sequencer for one fxp8s_pe lane: clear, row beats, column beats, drain,
// capture, respond. Optional job counter enabled by `define FXP8S_SEQ_PERF_EN.
module fxp8s_pe_seq
  import fxp8s_pkg::*;
#(
  parameter int VEC_LEN   = 3,
  parameter int MUL_LAT   = 1,
  parameter int DRAIN_CYC = MUL_LAT + 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [FXP8S_WIDTH-1:0] s_data,
  output logic                   pe_rstn,
  output logic                   pe_in_row,
  output logic                   pe_en_in,
  output logic [FXP8S_WIDTH-1:0] pe_in_data,
  output logic                   pe_en_out,
  input  logic [FXP8S_WIDTH-1:0] pe_out_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FXP8S_WIDTH-1:0] res_data,
`ifdef FXP8S_SEQ_PERF_EN
  output logic [15:0]            job_cnt,
`endif
  output logic                   busy
);

  localparam int BW = clog2(VEC_LEN);
  localparam int DW = clog2(DRAIN_CYC);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(VEC_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  seq_state_e    state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      res_data  <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      drain_cnt <= drain_nxt;
      if (state == ST_CAPT) res_data <= pe_out_data;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    drain_nxt = drain_cnt;
    s_ready   = 1'b0;
    pe_in_row = 1'b0;
    pe_en_out = 1'b0;
    res_valid = 1'b0;
    case (state)
      ST_IDLE: if (s_valid) state_nxt = ST_CLR;
      ST_CLR: begin
        beat_nxt  = '0;
        state_nxt = ST_ROW;
      end
      ST_ROW, ST_COL: begin
        s_ready   = 1'b1;
        pe_in_row = (state == ST_ROW);
        if (s_valid) begin
          if (beat_cnt == BEAT_LAST) begin
            beat_nxt  = '0;
            drain_nxt = '0;
            state_nxt = (state == ST_ROW) ? ST_COL : ST_DRAIN;
          end else begin
            beat_nxt = beat_cnt + BW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          drain_nxt = '0;
          state_nxt = ST_CAPT;
        end else begin
          drain_nxt = drain_cnt + DW'(1);
        end
      end
      ST_CAPT: begin
        pe_en_out = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand is gated outside ROW/COL so the PE bus idles at zero.
  assign pe_en_in   = s_valid & s_ready;
  assign pe_in_data = s_ready ? s_data : '0;
  assign pe_rstn    = rstn & (state != ST_CLR);
  assign busy       = (state != ST_IDLE);

`ifdef FXP8S_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      job_cnt <= '0;
    end else if (res_valid && res_ready && (job_cnt != '1)) begin
      job_cnt <= job_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fxp8s_pe_seq.sv
// Directed bench for fxp8s_pe_seq with a behavioural PE lane attached.
module tb_fxp8s_pe_seq;

  localparam int VEC_LEN   = 3;
  localparam int MUL_LAT   = 1;
  localparam int DRAIN_CYC = MUL_LAT + 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       pe_rstn, pe_in_row, pe_en_in, pe_en_out;
  logic [7:0] pe_in_data, pe_out_data;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;
`ifdef FXP8S_SEQ_PERF_EN
  logic [15:0] job_cnt;
`endif

  always #5 clk = ~clk;

  fxp8s_pe_seq #(.VEC_LEN(VEC_LEN), .MUL_LAT(MUL_LAT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pe_rstn(pe_rstn), .pe_in_row(pe_in_row), .pe_en_in(pe_en_in),
    .pe_in_data(pe_in_data), .pe_en_out(pe_en_out), .pe_out_data(pe_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef FXP8S_SEQ_PERF_EN
    .job_cnt(job_cnt),
`endif
    .busy(busy)
  );

  // PE lane: row buffer, one multiplier pipeline stage, wrapping accumulator.
  logic [7:0] rbuf [VEC_LEN];
  logic [1:0] wp, rp;
  logic [7:0] pipe, acc;

  function automatic logic [7:0] fx_mul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p[10:3];
  endfunction

  always @(posedge clk) begin
    if (!pe_rstn) begin
      acc <= '0; pipe <= '0; wp <= '0; rp <= '0;
    end else begin
      pipe <= '0;
      if (pe_en_in && pe_in_row) begin
        rbuf[wp] <= pe_in_data;
        wp <= (wp == 2'(VEC_LEN - 1)) ? 2'd0 : wp + 2'd1;
      end
      if (pe_en_in && !pe_in_row) begin
        pipe <= fx_mul(rbuf[rp], pe_in_data);
        rp <= (rp == 2'(VEC_LEN - 1)) ? 2'd0 : rp + 2'd1;
      end
      acc <= acc + pipe;
    end
  end
  assign pe_out_data = acc;

  int unsigned clr_cnt = 0;
  int unsigned bad_en  = 0;
  always @(negedge clk) begin
    if (rstn && !pe_rstn) clr_cnt++;
    if (pe_en_in && !s_valid) bad_en++;
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string         name;
    logic [7:0]    row [VEC_LEN];
    logic [7:0]    col [VEC_LEN];
    int unsigned   gap;
    logic [7:0]    exp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [7:0] r0, r1, r2,
                              input logic [7:0] c0, c1, c2,
                              input int unsigned g, input logic [7:0] e);
    vec_t v;
    v.name = n;
    v.row[0] = r0; v.row[1] = r1; v.row[2] = r2;
    v.col[0] = c0; v.col[1] = c1; v.col[2] = c2;
    v.gap = g; v.exp = e;
    return v;
  endfunction

  task automatic send_beat(input string name, input logic [7:0] d);
    int unsigned n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_accept"}, 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic feed(input vec_t v, input int unsigned n_col);
    for (int unsigned k = 0; k < VEC_LEN; k++) begin
      send_beat({v.name, "_row"}, v.row[k]);
      repeat (v.gap) tick();
    end
    for (int unsigned k = 0; k < n_col; k++) begin
      send_beat({v.name, "_col"}, v.col[k]);
      if (k + 1 < n_col) repeat (v.gap) tick();
    end
  endtask

  task automatic run_job(input vec_t v, input int unsigned hold);
    int unsigned lat;
    clr_cnt = 0;
    feed(v, VEC_LEN);
    lat = 1;
    while (!res_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({v.name, "_latency"}, lat, DRAIN_CYC + 2);
    chk({v.name, "_res_data"}, 32'(res_data), 32'(v.exp));
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      chk({v.name, "_hold_valid"}, 32'(res_valid), 32'd1);
      chk({v.name, "_hold_data"}, 32'(res_data), 32'(v.exp));
      chk({v.name, "_hold_sready"}, 32'(s_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({v.name, "_idle_valid"}, 32'(res_valid), 32'd0);
    chk({v.name, "_clr_cycles"}, clr_cnt, 32'd1);
  endtask

  vec_t vecs [5];
  vec_t basic;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    basic   = mk("basic",    8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 0, 8'h30);
    vecs[0] = basic;
    vecs[1] = mk("bubbles",  8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 2, 8'h30);
    vecs[2] = mk("ones",     8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 0, 8'h18);
    vecs[3] = mk("pairing",  8'h08, 8'h00, 8'h00, 8'h18, 8'h10, 8'h08, 0, 8'h18);
    vecs[4] = mk("negative", 8'hF8, 8'hF8, 8'hF8, 8'h10, 8'h10, 8'h10, 1, 8'hD0);

    // Reset state
    repeat (3) tick();
    chk("rst_s_ready",   32'(s_ready),   32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_pe_en_in",  32'(pe_en_in),  32'd0);
    chk("rst_pe_en_out", 32'(pe_en_out), 32'd0);
    chk("rst_pe_rstn",   32'(pe_rstn),   32'd0);
`ifdef FXP8S_SEQ_PERF_EN
    chk("rst_job_cnt",   32'(job_cnt),   32'd0);
`endif
    rstn = 1'b1;
    tick();
    chk("idle_pe_rstn", 32'(pe_rstn), 32'd1);

    for (int i = 0; i < 5; i++) run_job(vecs[i], 0);
    chk("en_without_valid", bad_en, 32'd0);
`ifdef FXP8S_SEQ_PERF_EN
    chk("job_cnt_5", 32'(job_cnt), 32'd5);
`endif

    // Back-pressure, then a back-to-back job with no accumulator carry-over
    run_job(mk("bp", 8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 0, 8'h30), 5);
    run_job(vecs[2], 0);

    // Reset mid-column: job discarded, res_data cleared
    feed(basic, 2);
    chk("midcol_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    tick();
    chk("midcol_busy",      32'(busy),      32'd0);
    chk("midcol_res_data",  32'(res_data),  32'd0);
    chk("midcol_res_valid", 32'(res_valid), 32'd0);
    chk("midcol_s_ready",   32'(s_ready),   32'd0);
    chk("midcol_pe_rstn",   32'(pe_rstn),   32'd0);
`ifdef FXP8S_SEQ_PERF_EN
    chk("midcol_job_cnt",   32'(job_cnt),   32'd0);
`endif
    rstn = 1'b1;
    tick();
    run_job(basic, 0);
`ifdef FXP8S_SEQ_PERF_EN
    chk("job_cnt_after_rst", 32'(job_cnt), 32'd1);
`endif
    chk("en_without_valid_end", bad_en, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
